// File: rtl/uart2wb.sv
// Far-end UART/Wishbone tunnel bridge: rebuilds request frames from received bytes,
// runs one Wishbone cycle per frame and sends the response. UART2WB_TIMEOUT_EN adds an ack watchdog.
module uart2wb #(
    parameter int addr_width     = 32,
    parameter int data_width     = 32,
    parameter int timeout_cycles = 1024
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic [7:0]            tx_data,
    output logic                  tx_load,
    input  logic                  tx_done,
    output logic                  wb_cyc,
    output logic                  wb_stb,
    output logic                  wb_we,
    output logic [addr_width-1:0] wb_adr,
    output logic [data_width-1:0] wb_datwr,
    output logic [((data_width/8 > 0) ? data_width/8 : 1)-1:0] wb_sel,
    input  logic [data_width-1:0] wb_datrd,
    input  logic                  wb_ack,
    output logic                  busy
);

    localparam int ABYTES = (addr_width / 8 > 0) ? addr_width / 8 : 1;
    localparam int DBYTES = (data_width / 8 > 0) ? data_width / 8 : 1;
    localparam int AW8    = ABYTES * 8;
    localparam int DW8    = DBYTES * 8;

    typedef enum logic [2:0] {IDLE, RX_ADDR, RX_DATA, RX_SEL, WB_REQ, TX_RESP} state_t;

    state_t              state_q;
    logic                we_q;
    logic [7:0]          cnt_q;
    logic [7:0]          last_q;
    logic [AW8-1:0]      addr_q;
    logic [DW8-1:0]      wdat_q;
    logic [DW8-1:0]      resp_q;
    logic [DBYTES-1:0]   sel_q;
    logic                cyc_q;
    logic                wbwe_q;
    logic                started_q;
    logic                txload_q;
    logic [7:0]          txdata_q;
`ifdef UART2WB_TIMEOUT_EN
    logic [31:0]         wdog_q;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            we_q      <= 1'b0;
            cnt_q     <= '0;
            last_q    <= '0;
            addr_q    <= '0;
            wdat_q    <= '0;
            resp_q    <= '0;
            sel_q     <= '0;
            cyc_q     <= 1'b0;
            wbwe_q    <= 1'b0;
            started_q <= 1'b0;
            txload_q  <= 1'b0;
            txdata_q  <= '0;
`ifdef UART2WB_TIMEOUT_EN
            wdog_q    <= '0;
`endif
        end else begin
            txload_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // Non-zero upper CMD bits mean we are out of frame sync; drop the byte.
                    if (rx_valid && rx_data[7:1] == 7'd0) begin
                        we_q    <= rx_data[0];
                        cnt_q   <= '0;
                        state_q <= RX_ADDR;
                    end
                end
                RX_ADDR: begin
                    if (rx_valid) begin
                        addr_q <= (addr_q >> 8) | (AW8'(rx_data) << (AW8 - 8));
                        if (cnt_q == 8'(ABYTES - 1)) begin
                            cnt_q <= '0;
                            if (we_q) begin
                                state_q <= RX_DATA;
                            end else begin
                                state_q <= WB_REQ;
                                cyc_q   <= 1'b1;
                                wbwe_q  <= 1'b0;
                            end
                        end else begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end
                end
                RX_DATA: begin
                    if (rx_valid) begin
                        wdat_q <= (wdat_q >> 8) | (DW8'(rx_data) << (DW8 - 8));
                        if (cnt_q == 8'(DBYTES - 1)) begin
                            cnt_q   <= '0;
                            state_q <= RX_SEL;
                        end else begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end
                end
                RX_SEL: begin
                    if (rx_valid) begin
                        sel_q   <= DBYTES'(rx_data);
                        state_q <= WB_REQ;
                        cyc_q   <= 1'b1;
                        wbwe_q  <= 1'b1;
                    end
                end
                WB_REQ: begin
                    if (wb_ack) begin
                        cyc_q     <= 1'b0;
                        wbwe_q    <= 1'b0;
                        resp_q    <= we_q ? DW8'(1) : DW8'(wb_datrd);
                        last_q    <= we_q ? 8'd0 : 8'(DBYTES - 1);
                        cnt_q     <= '0;
                        started_q <= 1'b0;
                        state_q   <= TX_RESP;
`ifdef UART2WB_TIMEOUT_EN
                        wdog_q    <= '0;
                    end else if (wdog_q == 32'(timeout_cycles - 1)) begin
                        cyc_q     <= 1'b0;
                        wbwe_q    <= 1'b0;
                        resp_q    <= '0;
                        last_q    <= we_q ? 8'd0 : 8'(DBYTES - 1);
                        cnt_q     <= '0;
                        started_q <= 1'b0;
                        wdog_q    <= '0;
                        state_q   <= TX_RESP;
                    end else begin
                        wdog_q <= wdog_q + 32'd1;
`endif
                    end
                end
                TX_RESP: begin
                    // Response is shifted out LSB byte first; each load consumes one byte.
                    if (!started_q) begin
                        started_q <= 1'b1;
                        txload_q  <= 1'b1;
                        txdata_q  <= resp_q[7:0];
                        resp_q    <= resp_q >> 8;
                    end else if (tx_done) begin
                        if (cnt_q == last_q) begin
                            started_q <= 1'b0;
                            cnt_q     <= '0;
                            state_q   <= IDLE;
                        end else begin
                            cnt_q    <= cnt_q + 8'd1;
                            txload_q <= 1'b1;
                            txdata_q <= resp_q[7:0];
                            resp_q   <= resp_q >> 8;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign wb_cyc   = cyc_q;
    assign wb_stb   = cyc_q;
    assign wb_we    = wbwe_q;
    assign wb_adr   = addr_width'(addr_q);
    assign wb_datwr = data_width'(wdat_q);
    assign wb_sel   = sel_q;
    assign tx_load  = txload_q;
    assign tx_data  = txdata_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_uart2wb.sv
// Directed bench for uart2wb (default build): read, write, resync, dropped bytes, resets.
module tb_uart2wb;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_load;
    logic        tx_done = 1'b0;
    logic        wb_cyc, wb_stb, wb_we;
    logic [31:0] wb_adr, wb_datwr;
    logic [3:0]  wb_sel;
    logic [31:0] wb_datrd = '0;
    logic        wb_ack = 1'b0;
    logic        busy;

    int tests = 0;
    int fails = 0;

    uart2wb #(.addr_width(32), .data_width(32), .timeout_cycles(1024)) dut (
        .clock(clock), .reset(reset),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_load(tx_load), .tx_done(tx_done),
        .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we),
        .wb_adr(wb_adr), .wb_datwr(wb_datwr), .wb_sel(wb_sel),
        .wb_datrd(wb_datrd), .wb_ack(wb_ack), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clock);
        rx_valid = 1'b0;
    endtask

    task automatic ack_after(input int waits, input logic [31:0] d);
        for (int i = 0; i < waits; i++) begin
            chk("cyc_stb_hold", {wb_cyc, wb_stb}, 2'b11);
            @(negedge clock);
        end
        wb_ack   = 1'b1;
        wb_datrd = d;
        @(negedge clock);
        wb_ack   = 1'b0;
        wb_datrd = '0;
        chk("cyc_stb_drop", {wb_cyc, wb_stb}, 2'b00);
    endtask

    task automatic tx_expect(input logic [7:0] exp, input bit last, input bit inject);
        int n = 0;
        while (tx_load !== 1'b1 && n < 40) begin
            @(negedge clock);
            n++;
        end
        chk("tx_load_seen", tx_load, 1'b1);
        chk("tx_data", tx_data, exp);
        @(negedge clock);
        chk("tx_load_pulse", tx_load, 1'b0);
        if (inject) send(8'h01);
        else @(negedge clock);
        tx_done = 1'b1;
        @(negedge clock);
        tx_done = 1'b0;
        chk(last ? "busy_after_last" : "busy_mid_tx", busy, !last);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: observed hang expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        @(negedge clock);
        @(negedge clock);
        chk("rst_cyc", wb_cyc, 1'b0);
        chk("rst_stb", wb_stb, 1'b0);
        chk("rst_we", wb_we, 1'b0);
        chk("rst_adr", wb_adr, 32'h0);
        chk("rst_datwr", wb_datwr, 32'h0);
        chk("rst_sel", wb_sel, 4'h0);
        chk("rst_txload", tx_load, 1'b0);
        chk("rst_txdata", tx_data, 8'h00);
        chk("rst_busy", busy, 1'b0);
        reset = 1'b0;
        @(negedge clock);

        // Read of 0x10, ack after 3 wait cycles.
        send(8'h00); chk("busy_in_frame", busy, 1'b1);
        send(8'h10); send(8'h00); send(8'h00);
        chk("rd_cyc_early", wb_cyc, 1'b0);
        send(8'h00);
        chk("rd_cyc", {wb_cyc, wb_stb}, 2'b11);
        chk("rd_we", wb_we, 1'b0);
        chk("rd_adr", wb_adr, 32'h0000_0010);
        ack_after(3, 32'hDEAD_BEEF);
        tx_expect(8'hEF, 0, 0);
        tx_expect(8'hBE, 0, 0);
        tx_expect(8'hAD, 0, 0);
        tx_expect(8'hDE, 1, 0);

        // Write with zero-wait ack.
        send(8'h01); send(8'h04); send(8'h00); send(8'h00); send(8'h00);
        send(8'h78); send(8'h56); send(8'h34); send(8'h12);
        chk("wr_cyc_early", wb_cyc, 1'b0);
        send(8'h0F);
        chk("wr_cyc", {wb_cyc, wb_stb}, 2'b11);
        chk("wr_we", wb_we, 1'b1);
        chk("wr_adr", wb_adr, 32'h0000_0004);
        chk("wr_datwr", wb_datwr, 32'h1234_5678);
        chk("wr_sel", wb_sel, 4'hF);
        ack_after(0, 32'h0);
        chk("wr_we_drop", wb_we, 1'b0);
        tx_expect(8'h01, 1, 0);

        // tx_done while idle must not start a transmission.
        tx_done = 1'b1;
        @(negedge clock);
        tx_done = 1'b0;
        chk("idle_txdone_load", tx_load, 1'b0);
        chk("idle_txdone_busy", busy, 1'b0);

        // Resync byte, then a read with bytes injected during the response.
        send(8'h82);
        chk("resync_busy", busy, 1'b0);
        send(8'h00); send(8'h20); send(8'h00); send(8'h00); send(8'h00);
        chk("rs_cyc", wb_cyc, 1'b1);
        chk("rs_adr", wb_adr, 32'h0000_0020);
        ack_after(0, 32'h1122_3344);
        tx_expect(8'h44, 0, 1);
        tx_expect(8'h33, 0, 1);
        tx_expect(8'h22, 0, 1);
        tx_expect(8'h11, 1, 0);
        send(8'h00); send(8'h08); send(8'h00); send(8'h00); send(8'h00);
        chk("drop_cyc", wb_cyc, 1'b1);
        chk("drop_adr", wb_adr, 32'h0000_0008);
        chk("drop_we", wb_we, 1'b0);
        ack_after(2, 32'hCAFE_F00D);
        tx_expect(8'h0D, 0, 0);
        tx_expect(8'hF0, 0, 0);
        tx_expect(8'hFE, 0, 0);
        tx_expect(8'hCA, 1, 0);

        // Reset after three address bytes, then a full write.
        send(8'h01); send(8'h04); send(8'h00); send(8'h00);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("mrst_busy", busy, 1'b0);
        chk("mrst_cyc", wb_cyc, 1'b0);
        chk("mrst_adr", wb_adr, 32'h0);
        send(8'h01); send(8'h00); send(8'h01); send(8'h00); send(8'h00);
        send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
        chk("mrst_cyc_early", wb_cyc, 1'b0);
        send(8'h03);
        chk("mrst_wr_cyc", wb_cyc, 1'b1);
        chk("mrst_wr_adr", wb_adr, 32'h0000_0100);
        chk("mrst_wr_dat", wb_datwr, 32'hDDCC_BBAA);
        chk("mrst_wr_sel", wb_sel, 4'h3);
        chk("mrst_wr_we", wb_we, 1'b1);
        ack_after(1, 32'h0);
        tx_expect(8'h01, 1, 0);

        // Reset in the middle of a Wishbone cycle.
        send(8'h00); send(8'h40); send(8'h00); send(8'h00); send(8'h00);
        chk("trst_cyc_pre", wb_cyc, 1'b1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("trst_cyc", {wb_cyc, wb_stb}, 2'b00);
        chk("trst_busy", busy, 1'b0);
        @(negedge clock);
        @(negedge clock);
        chk("trst_txload", tx_load, 1'b0);
        chk("trst_cyc_stay", wb_cyc, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
